// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced push-button event decoder
// Self-timed sampler plus press/release/long/repeat classifier for one raw button.
module button_event_decoder #(
  parameter int TICK_DIV     = 25_000_000,
  parameter int LONG_TICKS   = 8,
  parameter int REPEAT_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic tick,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int CNT_TOP = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CNT_N   = (CNT_TOP > 2) ? CNT_TOP : 2;
  localparam int CNT_W   = $clog2(CNT_N);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             s1_q, s2_q, q1_q, q2_q;
  state_t           state_q;
  logic [CNT_W-1:0] hold_cnt_q, rep_cnt_q;
  logic             level_q, press_q, release_q, long_q, repeat_q;
  logic             both1, both0;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      q1_q      <= 1'b0;
      q2_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      if (tick) begin
        q1_q <= s2_q;
        q2_q <= q1_q;
      end
    end
  end

  // Classification uses the sample pair as it stood before this tick's shift.
  assign both1 = q1_q & q2_q;
  assign both0 = ~q1_q & ~q2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (both1) begin
              state_q    <= PRESSED;
              level_q    <= 1'b1;
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
            end
          end
          PRESSED: begin
            if (both0) begin
              state_q   <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else if (both1) begin
              if (hold_cnt_q == LONG_LAST) begin
                state_q   <= LONG;
                long_q    <= 1'b1;
                rep_cnt_q <= '0;
              end else if (hold_cnt_q != CNT_SAT) begin
                hold_cnt_q <= hold_cnt_q + CNT_W'(1);
              end
            end
          end
          LONG: begin
            if (both0) begin
              state_q   <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else if (both1 && (REPEAT_TICKS != 0)) begin
              if (rep_cnt_q == REP_LAST) begin
                repeat_q  <= 1'b1;
                rep_cnt_q <= '0;
              end else if (rep_cnt_q != CNT_SAT) begin
                rep_cnt_q <= rep_cnt_q + CNT_W'(1);
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            level_q    <= 1'b0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed bench for button_event_decoder
// Second instance runs with repeat disabled on the same button and reset.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic tick, level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic tick2, level2, press2, release2, long2, repeat2;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;

  int press_cnt = 0, release_cnt = 0, long_cnt = 0, repeat_cnt = 0, multi_cnt = 0;
  int press_edge = 0, release_edge = 0, long_edge = 0, repeat_edge = 0;
  int long2_cnt = 0, repeat2_cnt = 0, long2_edge = 0;

  button_event_decoder #(.TICK_DIV(4), .LONG_TICKS(4), .REPEAT_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .tick(tick), .level(level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  button_event_decoder #(.TICK_DIV(4), .LONG_TICKS(4), .REPEAT_TICKS(0)) dut_norep (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .tick(tick2), .level(level2),
    .press_pulse(press2), .release_pulse(release2),
    .long_pulse(long2), .repeat_pulse(repeat2)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release; tick edges are multiples of 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (press_pulse)   begin press_cnt++;   press_edge   = ecnt; end
    if (release_pulse) begin release_cnt++; release_edge = ecnt; end
    if (long_pulse)    begin long_cnt++;    long_edge    = ecnt; end
    if (repeat_pulse)  begin repeat_cnt++;  repeat_edge  = ecnt; end
    if (long2)         begin long2_cnt++;   long2_edge   = ecnt; end
    if (repeat2)       repeat2_cnt++;
    if (int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)
      multi_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic align_tick();
    int guard = 0;
    while ((ecnt % 4) != 0 && guard < 8) begin
      wait_cyc(1);
      guard++;
    end
  endtask

  task automatic test_reset();
    wait_cyc(3);
    n_tests++;
    if ({tick, level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {tick, level, press_pulse, release_pulse, long_pulse, repeat_pulse});
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_tick_period();
    logic exp_tick;
    for (int i = 0; i < 40; i++) begin
      wait_cyc(1);
      exp_tick = ((ecnt % 4) == 3);
      n_tests++;
      if (tick !== exp_tick || {press_pulse, release_pulse, long_pulse, repeat_pulse} !== 4'b0) begin
        n_fail++;
        $display("FAIL tick_period cyc %0d: tick %b want %b pulses %b want 0000", ecnt, tick, exp_tick,
                 {press_pulse, release_pulse, long_pulse, repeat_pulse});
      end
    end
  endtask

  task automatic test_short_press();
    int t, p0, r0, l0, q0;
    align_tick();
    t = ecnt; p0 = press_cnt; r0 = release_cnt; l0 = long_cnt; q0 = repeat_cnt;
    btn_in = 1'b1;
    wait_cyc(20);
    n_tests++;
    if (level !== 1'b1) begin n_fail++; $display("FAIL short_level_high: got %b want 1", level); end
    btn_in = 1'b0;
    wait_cyc(16);
    n_tests++;
    if (press_cnt - p0 != 1 || press_edge != t + 12) begin
      n_fail++;
      $display("FAIL short_press: count %0d edge %0d want 1 at %0d", press_cnt - p0, press_edge, t + 12);
    end
    n_tests++;
    if (release_cnt - r0 != 1 || release_edge != t + 32) begin
      n_fail++;
      $display("FAIL short_release: count %0d edge %0d want 1 at %0d", release_cnt - r0, release_edge, t + 32);
    end
    n_tests++;
    if (long_cnt != l0 || repeat_cnt != q0 || level !== 1'b0) begin
      n_fail++;
      $display("FAIL short_no_long: long %0d repeat %0d level %b want 0 0 0",
               long_cnt - l0, repeat_cnt - q0, level);
    end
  endtask

  task automatic test_long_repeat();
    int t, p0, r0, l0, q0;
    align_tick();
    t = ecnt; p0 = press_cnt; r0 = release_cnt; l0 = long_cnt; q0 = repeat_cnt;
    btn_in = 1'b1;
    wait_cyc(38);
    n_tests++;
    if (long_cnt - l0 != 1 || long_edge != t + 28) begin
      n_fail++;
      $display("FAIL long_pulse: count %0d edge %0d want 1 at %0d", long_cnt - l0, long_edge, t + 28);
    end
    n_tests++;
    if (repeat_cnt - q0 != 1 || repeat_edge != t + 36) begin
      n_fail++;
      $display("FAIL first_repeat: count %0d edge %0d want 1 at %0d", repeat_cnt - q0, repeat_edge, t + 36);
    end
    wait_cyc(10);
    btn_in = 1'b0;
    wait_cyc(16);
    n_tests++;
    if (repeat_cnt - q0 != 3 || repeat_edge != t + 52) begin
      n_fail++;
      $display("FAIL repeat_train: count %0d last %0d want 3 last %0d", repeat_cnt - q0, repeat_edge, t + 52);
    end
    n_tests++;
    if (press_cnt - p0 != 1 || release_cnt - r0 != 1 || release_edge != t + 60) begin
      n_fail++;
      $display("FAIL long_press_release: press %0d release %0d at %0d want 1 1 at %0d",
               press_cnt - p0, release_cnt - r0, release_edge, t + 60);
    end
  endtask

  task automatic test_bounce();
    int p0, r0, l0, q0;
    align_tick();
    p0 = press_cnt; r0 = release_cnt; l0 = long_cnt; q0 = repeat_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_in = ((i % 2) == 0);
      wait_cyc(4);
      n_tests++;
      if (level !== 1'b0) begin n_fail++; $display("FAIL bounce_level tick %0d: got %b want 0", i, level); end
    end
    btn_in = 1'b0;
    wait_cyc(12);
    n_tests++;
    if (press_cnt != p0 || release_cnt != r0 || long_cnt != l0 || repeat_cnt != q0) begin
      n_fail++;
      $display("FAIL bounce_pulses: press %0d release %0d long %0d repeat %0d want all 0",
               press_cnt - p0, release_cnt - r0, long_cnt - l0, repeat_cnt - q0);
    end
  endtask

  task automatic test_glitch_pressed();
    int t, p0, r0, l0;
    align_tick();
    t = ecnt; p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    btn_in = 1'b1;
    wait_cyc(16);
    btn_in = 1'b0;
    wait_cyc(4);
    btn_in = 1'b1;
    wait_cyc(8);
    btn_in = 1'b0;
    wait_cyc(8);
    n_tests++;
    if (release_cnt != r0 || level !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_no_release: release %0d level %b want 0 1", release_cnt - r0, level);
    end
    wait_cyc(8);
    n_tests++;
    if (press_cnt - p0 != 1 || release_cnt - r0 != 1 || release_edge != t + 40 || long_cnt != l0) begin
      n_fail++;
      $display("FAIL glitch_final: press %0d release %0d at %0d long %0d want 1 1 at %0d 0",
               press_cnt - p0, release_cnt - r0, release_edge, long_cnt - l0, t + 40);
    end
  endtask

  task automatic test_reset_mid_hold();
    int p0, l0;
    align_tick();
    l0 = long_cnt;
    btn_in = 1'b1;
    wait_cyc(30);
    n_tests++;
    if (long_cnt - l0 != 1 || level !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_long: long %0d level %b want 1 1", long_cnt - l0, level);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tick, level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b want 000000",
               {tick, level, press_pulse, release_pulse, long_pulse, repeat_pulse});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    p0 = press_cnt; l0 = long_cnt;
    wait_cyc(30);
    n_tests++;
    if (press_cnt - p0 != 1 || press_edge != 12) begin
      n_fail++;
      $display("FAIL reset_repress: count %0d edge %0d want 1 at 12", press_cnt - p0, press_edge);
    end
    n_tests++;
    if (long_cnt - l0 != 1 || long_edge != 28) begin
      n_fail++;
      $display("FAIL reset_relong: count %0d edge %0d want 1 at 28", long_cnt - l0, long_edge);
    end
    btn_in = 1'b0;
    wait_cyc(24);
  endtask

  task automatic test_repeat_disabled();
    int t, l0, q0;
    align_tick();
    t = ecnt; l0 = long2_cnt; q0 = repeat2_cnt;
    btn_in = 1'b1;
    wait_cyc(48);
    btn_in = 1'b0;
    wait_cyc(16);
    n_tests++;
    if (long2_cnt - l0 != 1 || long2_edge != t + 28) begin
      n_fail++;
      $display("FAIL norep_long: count %0d edge %0d want 1 at %0d", long2_cnt - l0, long2_edge, t + 28);
    end
    n_tests++;
    if (repeat2_cnt != q0 || level2 !== 1'b0) begin
      n_fail++;
      $display("FAIL norep_repeat: count %0d level %b want 0 0", repeat2_cnt - q0, level2);
    end
  endtask

  task automatic test_one_hot_pulses();
    n_tests++;
    if (multi_cnt != 0) begin
      n_fail++;
      $display("FAIL one_pulse_per_cycle: got %0d overlapping cycles want 0", multi_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_short_press();
    test_long_repeat();
    test_bounce();
    test_glitch_pressed();
    test_reset_mid_hold();
    test_repeat_disabled();
    test_one_hot_pulses();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumer side of the push-button debounce chain.
- Generates its own slow sample strobe, samples one raw button through a synchronizer and a two-stage enabled-DFF chain, and classifies the stable level into single-cycle events: press, release, long-press and auto-repeat.
- Sits between the board button pins and the mode/temperature control FSMs, which use its pulses directly as clk-domain events.

Parameters:
- TICK_DIV, 25_000_000, clk cycles per sample tick (4 Hz at 100 MHz); legal range ≥2.
- LONG_TICKS, 8, ticks held after press before long_pulse (2 s); legal range ≥1.
- REPEAT_TICKS, 2, ticks between repeat_pulse while long-held (500 ms); 0 disables repeat.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw button pin, active-high, asynchronous to clk.
- tick  output  1  one-cycle sample strobe.
- level  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse on debounced press.
- release_pulse  output  1  one-cycle pulse on debounced release.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_TICKS.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_TICKS while long-held.

Behaviour:
- Reset:
  - Single clock `clk`; `rst_n` is asynchronous and active-low.
  - While rst_n=0, all registers and outputs are 0 and the FSM is IDLE.
  - Reset asserted mid-press: no pulse is emitted. After release of reset, a still-held button produces a fresh press_pulse after the normal latency.
- Tick generator:
  - div_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 exactly in cycles where div_cnt==TICK_DIV-1.
  - Width is clog2(TICK_DIV).
- Synchronizer: s1<=btn_in, s2<=s1 on every clk.
- Sample chain: on clk edges where tick=1, q1<=s2 and q2<=q1. Otherwise q1 and q2 hold.
- Evaluation:
  - The FSM evaluates only on clk edges where tick=1, using the pre-update q1 and q2.
  - both1 = q1&q2; both0 = ~q1&~q2; mixed means hold state and counters.
- FSM:
  - IDLE (level=0): on tick with both1 → PRESSED; press_pulse; hold_cnt<=0.
  - PRESSED (level=1), on tick:
    - both0 → IDLE; release_pulse.
    - both1 with hold_cnt==LONG_TICKS-1 → LONG; long_pulse; rep_cnt<=0.
    - both1 otherwise → hold_cnt++.
  - LONG (level=1), on tick:
    - both0 → IDLE; release_pulse.
    - both1 with REPEAT_TICKS≠0 and rep_cnt==REPEAT_TICKS-1 → repeat_pulse; rep_cnt<=0.
    - both1 otherwise → rep_cnt++ when REPEAT_TICKS≠0.
  - Undefined state encodings → IDLE.
- Pulse outputs:
  - All pulses and level are registered.
  - A pulse is high for exactly the one clk cycle following the tick edge that caused it.
  - At most one event pulse is high per cycle.
- Latency:
  - A btn_in rise that is stable ≥2 clk before tick k is captured into q1 at tick k.
  - press_pulse follows tick k+2.
  - long_pulse follows the tick LONG_TICKS ticks after the press tick.
  - Release has symmetric latency.
- Bounce rejection: any glitch present at only one sample (mixed q1/q2) never changes state.
- Counter sizing: hold_cnt and rep_cnt are sized clog2(max(LONG_TICKS,REPEAT_TICKS,2)) and saturate; they never wrap.

Test Plan (TICK_DIV=4, LONG_TICKS=4, REPEAT_TICKS=2):
- Tick period: after reset release, observe tick for 40 cycles → tick high exactly every 4th cycle (div_cnt==3), with no other pulses.
- Short press:
  - Stimulus: btn_in=1 for 5 ticks, then 0.
  - Required: one press_pulse 2 ticks after first capture; level=1 until release; one release_pulse 2 ticks after the first low capture.
  - Required: no long_pulse or repeat_pulse.
- Long press with repeat:
  - Stimulus: btn_in=1 held for 12 ticks.
  - Required: press_pulse; long_pulse 4 ticks later; repeat_pulse at +2 and +4 ticks after long_pulse, continuing every 2 ticks; release_pulse after button drop.
- Bounce:
  - Stimulus: btn_in toggles between alternate ticks (high at one sample, low at the next) for 10 ticks.
  - Required: no pulses; level stays 0.
  - Stimulus: a 1-tick low glitch while in PRESSED.
  - Required: no release_pulse.
- Reset mid-hold:
  - Stimulus: rst_n=0 for 3 cycles while in LONG with the button still held.
  - Required: all outputs 0 immediately (asynchronous); after reset, press_pulse reoccurs 2–3 ticks later and long_pulse again 4 ticks after that.
- Repeat disabled:
  - Stimulus: REPEAT_TICKS=0, button held 12 ticks.
  - Required: exactly one long_pulse and zero repeat_pulse.
